// File: rtl/hazard_branch_ctrl.sv
// hazard_branch_ctrl: ID-stage hazard detection, stall sequencing and
// branch/jump redirect control for the fetch-side PC, plus stall and
// redirect event counters for performance debug.
module hazard_branch_ctrl #(
    parameter int PC_WIDTH = 32,
    parameter int RA_W     = 5,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [RA_W-1:0]     id_rs1,
    input  logic [RA_W-1:0]     id_rs2,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic                id_is_bj,
    input  logic                id_bj_taken,
    input  logic [PC_WIDTH-1:0] id_target_pc,
    input  logic [RA_W-1:0]     ex_rd,
    input  logic                ex_reg_write,
    input  logic                ex_mem_read,
    input  logic [RA_W-1:0]     mem_rd,
    input  logic                mem_mem_read,
    output logic                stall,
    output logic                pc_src,
    output logic [PC_WIDTH-1:0] target_pc,
    output logic                flush_if_id,
    output logic                bubble_id_ex,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    redirect_cnt
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t state;
    state_t state_next;

    logic rs1_ex_match;
    logic rs2_ex_match;
    logic rs1_mem_match;
    logic rs2_mem_match;
    logic ex_match;
    logic mem_match;
    logic hazard_two;
    logic hazard_one;

    // Source/producer register matching; x0 never matches
    always_comb begin
        rs1_ex_match  = id_use_rs1 && (id_rs1 != '0) && (id_rs1 == ex_rd);
        rs2_ex_match  = id_use_rs2 && (id_rs2 != '0) && (id_rs2 == ex_rd);
        rs1_mem_match = id_use_rs1 && (id_rs1 != '0) && (id_rs1 == mem_rd);
        rs2_mem_match = id_use_rs2 && (id_rs2 != '0) && (id_rs2 == mem_rd);
        ex_match      = rs1_ex_match || rs2_ex_match;
        mem_match     = rs1_mem_match || rs2_mem_match;
    end

    // Hazard classification: two-cycle (branch on EX load) and one-cycle cases
    always_comb begin
        hazard_two = id_valid && id_is_bj && ex_match && ex_mem_read;
        hazard_one = id_valid && (
                         (id_is_bj  && ex_match  && ex_reg_write && !ex_mem_read) ||
                         (id_is_bj  && mem_match && mem_mem_read) ||
                         (!id_is_bj && ex_match  && ex_mem_read));
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: a two-cycle hazard parks in HOLD for exactly one extra cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (hazard_two) state_next = HOLD;
            HOLD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: stall wins over redirect; everything is held low during reset
    always_comb begin
        stall        = 1'b0;
        pc_src       = 1'b0;
        target_pc    = '0;
        flush_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    stall = hazard_two || hazard_one;
                HOLD:    stall = 1'b1;
                default: stall = 1'b0;
            endcase
            pc_src       = id_valid && id_bj_taken && !stall;
            target_pc    = id_target_pc;
            flush_if_id  = pc_src;
            bubble_id_ex = stall;
        end
    end

    // Performance event counters, wrapping naturally at 2^CNT_W
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            if (stall) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (pc_src) begin
                redirect_cnt <= redirect_cnt + CNT_W'(1);
            end
        end
    end

endmodule
